// File: rtl/i2s_tx_pkg.sv
// Shared types and constants for the I2S DSP/TDM transmit channel.
package i2s_tx_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFSET = 2'd1,
    RUN    = 2'd2
  } i2s_tx_state_e;

endpackage

// File: rtl/i2s_tx_word_serializer.sv
// One SD lane: loads a word and shifts it out one bit per sck edge,
// MSB-first (starting at bit num_bits) or LSB-first (starting at bit 0).
// Bits above num_bits are never reached, so they are ignored.
module i2s_tx_word_serializer
  import i2s_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  input  logic [4:0]        num_bits,
  input  logic              lsb_first,
  output logic              sd
);

  logic [WORD_W-1:0] sr_q;

  // Shift register and registered lane output; clear wins, then load, then shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
      sd   <= 1'b0;
    end else if (clr) begin
      sr_q <= '0;
      sd   <= 1'b0;
    end else if (load) begin
      if (lsb_first) begin
        sd   <= load_data[0];
        sr_q <= load_data >> 1;
      end else begin
        sd   <= load_data[num_bits];
        sr_q <= load_data << 1;
      end
    end else if (shift) begin
      if (lsb_first) begin
        sd   <= sr_q[0];
        sr_q <= sr_q >> 1;
      end else begin
        sd   <= sr_q[num_bits];
        sr_q <= sr_q << 1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_dsp_channel.sv
// Slave-mode DSP/TDM transmitter: pops words from the uDMA TX FIFO and
// serializes them on one or two SD lanes, framed by an external WS.
// Optional feature: define I2S_TX_UNDERRUN_REPEAT_EN to replay the last
// transmitted word(s) on underrun instead of sending zeros.
//
// FIFO handshake: a word transfers on a posedge where fifo_data_valid_i and
// fifo_data_ready_o are both high; ready depends only on enable, reset and
// buffer occupancy (never on valid), and a word is never consumed on the
// same edge one is accepted because ready is low whenever the buffer is full.
module i2s_tx_dsp_channel
  import i2s_tx_pkg::*;
(
  input  logic              sck_i,
  input  logic              rst_i,
  input  logic              i2s_ws_i,
  output logic              i2s_ch0_o,
  output logic              i2s_ch1_o,
  input  logic [WORD_W-1:0] fifo_data_i,
  input  logic              fifo_data_valid_i,
  output logic              fifo_data_ready_o,
  output logic              fifo_err_o,
  input  logic              cfg_en_i,
  input  logic              cfg_2ch_i,
  input  logic [4:0]        cfg_num_bits_i,
  input  logic [3:0]        cfg_num_word_i,
  input  logic              cfg_lsb_first_i,
  input  logic              cfg_tx_continuous_i,
  input  logic [8:0]        cfg_slave_dsp_offset_i,
  output logic [1:0]        dbg_state_o
);

  i2s_tx_state_e     state_q, state_d;
  logic [8:0]        cnt_off_q;
  logic [4:0]        cnt_bit_q;
  logic [3:0]        cnt_word_q;
  logic [WORD_W-1:0] buf0_q, buf1_q;
  logic              buf0_v_q, buf1_v_q;
  logic              err_q;
  logic              word_start, burst_end, shift_en, lane_clr;
  logic              buf_full, consume, underrun, accept;
  logic [WORD_W-1:0] load0, load1;
  logic              sd0, sd1;

  assign buf_full          = buf0_v_q & (~cfg_2ch_i | buf1_v_q);
  assign fifo_data_ready_o = cfg_en_i & ~rst_i & (~buf0_v_q | (cfg_2ch_i & ~buf1_v_q));
  assign accept            = fifo_data_valid_i & fifo_data_ready_o;
  assign consume           = word_start & buf_full;
  assign underrun          = word_start & ~buf_full;
  assign lane_clr          = ~cfg_en_i | burst_end;

  // State register.
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus word-start / shift / burst-end strobes.
  always_comb begin
    state_d    = state_q;
    word_start = 1'b0;
    burst_end  = 1'b0;
    shift_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i2s_ws_i) begin
          if (cfg_slave_dsp_offset_i == 9'd0) begin
            state_d    = RUN;
            word_start = 1'b1;
          end else begin
            state_d = OFFSET;
          end
        end
      end
      OFFSET: begin
        if (cnt_off_q == cfg_slave_dsp_offset_i) begin
          state_d    = RUN;
          word_start = 1'b1;
        end
      end
      RUN: begin
        if (cnt_bit_q == cfg_num_bits_i) begin
          if (!cfg_tx_continuous_i && (cnt_word_q == cfg_num_word_i)) begin
            state_d   = IDLE;
            burst_end = 1'b1;
          end else begin
            word_start = 1'b1;
          end
        end else begin
          shift_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!cfg_en_i) begin
      state_d    = IDLE;
      word_start = 1'b0;
      burst_end  = 1'b0;
      shift_en   = 1'b0;
    end
  end

  // Offset, bit and word counters; all cleared on disable or when idle.
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_off_q  <= '0;
      cnt_bit_q  <= '0;
      cnt_word_q <= '0;
    end else if (!cfg_en_i) begin
      cnt_off_q  <= '0;
      cnt_bit_q  <= '0;
      cnt_word_q <= '0;
    end else begin
      if (state_d == OFFSET)
        cnt_off_q <= (state_q == OFFSET) ? cnt_off_q + 9'd1 : 9'd1;
      else
        cnt_off_q <= '0;

      if (word_start || burst_end) cnt_bit_q <= '0;
      else if (shift_en)           cnt_bit_q <= cnt_bit_q + 5'd1;

      if (state_d == IDLE)                    cnt_word_q <= '0;
      else if (state_q == RUN && word_start)  cnt_word_q <= cnt_word_q + 4'd1;
    end
  end

  // Two-word staging buffer between the FIFO and the lane shift registers.
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      buf0_q   <= '0;
      buf1_q   <= '0;
      buf0_v_q <= 1'b0;
      buf1_v_q <= 1'b0;
    end else if (!cfg_en_i) begin
      buf0_q   <= '0;
      buf1_q   <= '0;
      buf0_v_q <= 1'b0;
      buf1_v_q <= 1'b0;
    end else if (consume) begin
      buf0_v_q <= 1'b0;
      buf1_v_q <= 1'b0;
    end else if (accept) begin
      if (!buf0_v_q) begin
        buf0_q   <= fifo_data_i;
        buf0_v_q <= 1'b1;
      end else begin
        buf1_q   <= fifo_data_i;
        buf1_v_q <= 1'b1;
      end
    end
  end

  // Underrun flag: one cycle high after a word start that found the buffer short.
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= underrun;
  end

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [WORD_W-1:0] rep0_q, rep1_q;

  // Copy of the last word pair actually sent, replayed on underrun.
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      rep0_q <= '0;
      rep1_q <= '0;
    end else if (!cfg_en_i) begin
      rep0_q <= '0;
      rep1_q <= '0;
    end else if (consume) begin
      rep0_q <= buf0_q;
      rep1_q <= cfg_2ch_i ? buf1_q : '0;
    end
  end

  // Lane load data: fresh buffer contents, or the replay copy on underrun.
  always_comb begin
    load0 = rep0_q;
    load1 = rep1_q;
    if (consume) begin
      load0 = buf0_q;
      load1 = cfg_2ch_i ? buf1_q : '0;
    end
  end
`else
  // Lane load data: fresh buffer contents, or zeros on underrun.
  always_comb begin
    load0 = '0;
    load1 = '0;
    if (consume) begin
      load0 = buf0_q;
      load1 = cfg_2ch_i ? buf1_q : '0;
    end
  end
`endif

  i2s_tx_word_serializer u_lane0 (
    .clk       (sck_i),
    .rst       (rst_i),
    .clr       (lane_clr),
    .load      (word_start),
    .shift     (shift_en),
    .load_data (load0),
    .num_bits  (cfg_num_bits_i),
    .lsb_first (cfg_lsb_first_i),
    .sd        (sd0)
  );

  i2s_tx_word_serializer u_lane1 (
    .clk       (sck_i),
    .rst       (rst_i),
    .clr       (lane_clr),
    .load      (word_start),
    .shift     (shift_en),
    .load_data (load1),
    .num_bits  (cfg_num_bits_i),
    .lsb_first (cfg_lsb_first_i),
    .sd        (sd1)
  );

  assign i2s_ch0_o   = sd0;
  assign i2s_ch1_o   = sd1 & cfg_2ch_i;
  assign fifo_err_o  = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2s_tx_dsp_channel.sv
// Self-checking bench for i2s_tx_dsp_channel: directed scenarios with literal
// expectations plus a randomized run against a frame-level reference model.
module tb_i2s_tx_dsp_channel;
  import i2s_tx_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        sck = 1'b0;
  logic        rst, ws, valid, en, c2ch, lsb, cont;
  logic [31:0] data;
  logic [4:0]  nb;
  logic [3:0]  nw;
  logic [8:0]  off;
  logic        ch0, ch1, ready, err;
  logic [1:0]  dbg;

  always #5 sck = ~sck;

  i2s_tx_dsp_channel dut (
    .sck_i                  (sck),
    .rst_i                  (rst),
    .i2s_ws_i               (ws),
    .i2s_ch0_o              (ch0),
    .i2s_ch1_o              (ch1),
    .fifo_data_i            (data),
    .fifo_data_valid_i      (valid),
    .fifo_data_ready_o      (ready),
    .fifo_err_o             (err),
    .cfg_en_i               (en),
    .cfg_2ch_i              (c2ch),
    .cfg_num_bits_i         (nb),
    .cfg_num_word_i         (nw),
    .cfg_lsb_first_i        (lsb),
    .cfg_tx_continuous_i    (cont),
    .cfg_slave_dsp_offset_i (off),
    .dbg_state_o            (dbg)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO source (the uDMA side) ----------------
  logic [31:0] src_q[$];
  int          valid_pct = 100;
  logic        hs;

  // ---------------- reference model ----------------
  // Frame-level view: a word start pushes a whole word's bits (in wire order)
  // into per-lane bit queues; every following edge pops one bit until the
  // word is exhausted. Buffered words are a queue capped at 1 or 2 entries.
  int          m_mode;     // 0 idle, 1 waiting out offset, 2 transmitting
  int          m_wait;
  int          m_done;     // words started in this burst
  logic [31:0] m_buf[$];
  logic        q0[$], q1[$];
  logic [31:0] m_last0, m_last1;
  logic        e_sd0, e_sd1, e_err;

  function automatic int m_cap();
    return c2ch ? 2 : 1;
  endfunction

  function automatic logic m_ready();
    return en && !rst && (m_buf.size() < m_cap());
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_wait = 0; m_done = 0;
    m_buf.delete(); q0.delete(); q1.delete();
    m_last0 = '0; m_last1 = '0;
    e_sd0 = 1'b0; e_sd1 = 1'b0; e_err = 1'b0;
  endfunction

  function automatic void model_step();
    logic        acc, start;
    logic [31:0] w0, w1;
    int          idx;
    acc   = valid && m_ready();
    start = 1'b0;
    if (!en) begin
      model_reset();
      return;
    end
    e_err = 1'b0;
    case (m_mode)
      0: if (ws) begin
           if (off == 0) start = 1'b1;
           else begin m_mode = 1; m_wait = int'(off); end
         end
      1: begin
           m_wait--;
           if (m_wait == 0) start = 1'b1;
         end
      default: begin
        if (q0.size() == 0) begin
          if (!cont && m_done == int'(nw) + 1) begin
            m_mode = 0; e_sd0 = 1'b0; e_sd1 = 1'b0;
          end else start = 1'b1;
        end else begin
          e_sd0 = q0.pop_front();
          e_sd1 = q1.pop_front();
        end
      end
    endcase
    if (start) begin
      if (m_mode != 2) m_done = 0;
      m_mode = 2;
      if (m_buf.size() == m_cap()) begin
        w0 = m_buf.pop_front();
        w1 = c2ch ? m_buf.pop_front() : 32'h0;
        m_last0 = w0; m_last1 = w1;
      end else begin
        e_err = 1'b1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        w0 = m_last0; w1 = m_last1;
`else
        w0 = 32'h0; w1 = 32'h0;
`endif
      end
      m_done++;
      for (int i = 0; i <= int'(nb); i++) begin
        idx = lsb ? i : int'(nb) - i;
        q0.push_back(w0[idx]);
        q1.push_back(c2ch ? w1[idx] : 1'b0);
      end
      e_sd0 = q0.pop_front();
      e_sd1 = q1.pop_front();
    end
    if (acc) m_buf.push_back(data);
  endfunction

  // Model advance and FIFO source handshake on each active edge.
  always @(posedge sck) begin
    hs = valid && ready;
    if (rst) model_reset();
    else     model_step();
    if (hs && src_q.size() > 0) void'(src_q.pop_front());
    #1;
    valid = (src_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
    data  = (src_q.size() > 0) ? src_q[0] : $urandom;
  end

  // Compare process: every cycle on the falling edge.
  always @(negedge sck) begin
    if (chk_en && !rst) begin
      logic [1:0] exp_state;
      exp_state = (m_mode == 0) ? IDLE : (m_mode == 1) ? OFFSET : RUN;
      check("ch0",   {31'h0, ch0},   {31'h0, e_sd0});
      check("ch1",   {31'h0, ch1},   {31'h0, e_sd1});
      check("err",   {31'h0, err},   {31'h0, e_err});
      check("ready", {31'h0, ready}, {31'h0, m_ready()});
      check("state", {30'h0, dbg},   {30'h0, exp_state});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge sck);
      #2;
    end
  endtask

  task automatic configure(input logic t2ch, input logic [4:0] tnb, input logic [3:0] tnw,
                           input logic tlsb, input logic tcont, input logic [8:0] toff);
    en = 1'b0; ws = 1'b0;
    cycle(1);
    src_q.delete();
    valid = 1'b0;
    valid_pct = 100;
    c2ch = t2ch; nb = tnb; nw = tnw; lsb = tlsb; cont = tcont; off = toff;
    en = 1'b1;
    cycle(1);
  endtask

  task automatic ws_pulse();
    ws = 1'b1;
    cycle(1);
    ws = 1'b0;
  endtask

  logic [15:0] cap0, cap1;
  int          errcnt;

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; en = 1'b1; ws = 1'b0; valid = 1'b0; data = '0;
    c2ch = 1'b0; nb = 5'd15; nw = 4'd0; lsb = 1'b0; cont = 1'b0; off = '0;
    #1;
    check("rst_ch0",   {31'h0, ch0},   32'h0);
    check("rst_ch1",   {31'h0, ch1},   32'h0);
    check("rst_err",   {31'h0, err},   32'h0);
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_state", {30'h0, dbg},   {30'h0, IDLE});
    cycle(3);
    en  = 1'b0;
    rst = 1'b0;
    cycle(1);
    chk_en = 1'b1;

    // 1ch, 16-bit MSB first, offset 0
    configure(1'b0, 5'd15, 4'd0, 1'b0, 1'b0, 9'd0);
    src_q.push_back(32'hFFFF_A5C3);
    cycle(3);
    ws_pulse();
    cap0 = '0;
    for (int i = 0; i < 16; i++) begin
      cap0 = {cap0[14:0], ch0};
      cycle(1);
    end
    check("t1_seq",  {16'h0, cap0}, 32'h0000_A5C3);
    check("t1_idle", {30'h0, dbg},  {30'h0, IDLE});

    // 2ch, 8-bit LSB first, offset 3
    configure(1'b1, 5'd7, 4'd0, 1'b1, 1'b0, 9'd3);
    src_q.push_back(32'h01);
    src_q.push_back(32'h80);
    cycle(4);
    ws_pulse();
    check("t2_offset_state", {30'h0, dbg}, {30'h0, OFFSET});
    cycle(2);
    check("t2_pre_ch0", {31'h0, ch0}, 32'h0);
    cycle(1);
    cap0 = '0; cap1 = '0;
    for (int i = 0; i < 8; i++) begin
      cap0 = {cap0[14:0], ch0};
      cap1 = {cap1[14:0], ch1};
      cycle(1);
    end
    check("t2_ch0", {16'h0, cap0}, 32'h80);
    check("t2_ch1", {16'h0, cap1}, 32'h01);

    // non-continuous, two words per burst, four queued
    configure(1'b0, 5'd7, 4'd1, 1'b0, 1'b0, 9'd0);
    src_q.push_back(32'h11); src_q.push_back(32'h22);
    src_q.push_back(32'h33); src_q.push_back(32'h44);
    cycle(3);
    ws_pulse();
    for (int i = 0; i < 16; i++) begin
      cap0 = {cap0[14:0], ch0};
      cycle(1);
    end
    check("t3_burst1", {16'h0, cap0}, 32'h1122);
    cycle(3);
    check("t3_idle_state", {30'h0, dbg}, {30'h0, IDLE});
    check("t3_idle_sd",    {31'h0, ch0}, 32'h0);
    ws_pulse();
    for (int i = 0; i < 16; i++) begin
      cap0 = {cap0[14:0], ch0};
      cycle(1);
    end
    check("t3_burst2", {16'h0, cap0}, 32'h3344);

    // continuous, FIFO starved after one word
    configure(1'b0, 5'd7, 4'd0, 1'b0, 1'b1, 9'd0);
    src_q.push_back(32'h5A);
    cycle(3);
    ws_pulse();
    errcnt = 0;
    for (int i = 0; i < 16; i++) begin
      cap0 = {cap0[14:0], ch0};
      errcnt += int'(err);
      cycle(1);
    end
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    check("t4_seq", {16'h0, cap0}, 32'h5A5A);
`else
    check("t4_seq", {16'h0, cap0}, 32'h5A00);
`endif
    check("t4_err_pulses", errcnt, 32'd1);

    // disable mid-word at bit 5
    configure(1'b0, 5'd15, 4'd0, 1'b0, 1'b1, 9'd0);
    repeat (3) src_q.push_back(32'hFFFF_FFFF);
    cycle(3);
    ws_pulse();
    cycle(5);
    check("t5_bit5", {31'h0, ch0}, 32'h1);
    en = 1'b0;
    cycle(1);
    check("t5_state", {30'h0, dbg},   {30'h0, IDLE});
    check("t5_sd",    {31'h0, ch0},   32'h0);
    check("t5_ready", {31'h0, ready}, 32'h0);
    en = 1'b1;
    #1;
    check("t5_reready", {31'h0, ready}, 32'h1);
    cycle(2);

    // asynchronous reset mid-run
    configure(1'b0, 5'd15, 4'd0, 1'b0, 1'b1, 9'd0);
    repeat (3) src_q.push_back(32'hFFFF_FFFF);
    cycle(3);
    ws_pulse();
    cycle(4);
    check("t6_pre_ch0", {31'h0, ch0}, 32'h1);
    rst = 1'b1;
    #1;
    check("t6_ch0",   {31'h0, ch0},   32'h0);
    check("t6_err",   {31'h0, err},   32'h0);
    check("t6_ready", {31'h0, ready}, 32'h0);
    check("t6_state", {30'h0, dbg},   {30'h0, IDLE});
    cycle(1);
    check("t6_ready_held", {31'h0, ready}, 32'h0);
    rst = 1'b0;
    #1;
    check("t6_ready_rel", {31'h0, ready}, 32'h1);
    cycle(2);

    // randomized configurations against the model
    for (int it = 0; it < 25; it++) begin
      logic [4:0] rnb;
      case ($urandom_range(0, 4))
        0: rnb = 5'd7;
        1: rnb = 5'd15;
        2: rnb = 5'd23;
        3: rnb = 5'd31;
        default: rnb = 5'($urandom_range(0, 31));
      endcase
      configure(1'($urandom_range(0, 1)), rnb, 4'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 40)) : 9'($urandom_range(0, 4)));
      valid_pct = $urandom_range(30, 100);
      for (int c = 0; c < 300; c++) begin
        ws = ($urandom_range(0, 40) == 0);
        en = ($urandom_range(0, 199) != 0);
        if (src_q.size() < 3) src_q.push_back($urandom);
        cycle(1);
      end
    end

    chk_en = 1'b0;
    en = 1'b0; ws = 1'b0;
    cycle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
